// File: rtl/timer_periph.sv
// timer_periph: memory-mapped timer / board-IO responder on the MEM-stage bus.
// Holds a 32-bit auto-reload counter (TH/TL/TCON), LED and 7-segment output
// registers, and a read-only view of the board switches. Loads are answered
// combinationally in the same cycle; stores commit on the rising clock edge.
//
// Bus handshake: there is no valid/ready pair. The pipeline asserts rd and/or
// wr for exactly the cycle it owns the access; the responder never stalls.
// rdata is valid whenever rd=1 in that cycle, and a write is taken on the edge
// that closes a cycle with wr=1. rd and wr may be high together; the read then
// returns the value held before the write lands.

module timer_periph #(
    parameter logic [31:0] TIMER_BASE = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        supervisor,
    input  logic [7:0]  switch,
    output logic [7:0]  led,
    output logic [11:0] digi,
    output logic        irq
);

    // Register offsets inside the window.
    localparam logic [31:0] OFF_TH     = 32'h0000_0000;
    localparam logic [31:0] OFF_TL     = 32'h0000_0004;
    localparam logic [31:0] OFF_TCON   = 32'h0000_0008;
    localparam logic [31:0] OFF_LED    = 32'h0000_000C;
    localparam logic [31:0] OFF_SWITCH = 32'h0000_0010;
    localparam logic [31:0] OFF_DIGI   = 32'h0000_0014;

    // Absolute addresses; decode is an exact 32-bit match, no aliasing.
    localparam logic [31:0] ADDR_TH     = TIMER_BASE + OFF_TH;
    localparam logic [31:0] ADDR_TL     = TIMER_BASE + OFF_TL;
    localparam logic [31:0] ADDR_TCON   = TIMER_BASE + OFF_TCON;
    localparam logic [31:0] ADDR_LED    = TIMER_BASE + OFF_LED;
    localparam logic [31:0] ADDR_SWITCH = TIMER_BASE + OFF_SWITCH;
    localparam logic [31:0] ADDR_DIGI   = TIMER_BASE + OFF_DIGI;

    // TCON bit positions.
    localparam int TCON_EN  = 0;
    localparam int TCON_IE  = 1;
    localparam int TCON_STS = 2;

    // Architectural registers.
    logic [31:0] r_th;
    logic [31:0] r_tl;
    logic [2:0]  r_tcon;
    logic [7:0]  r_led;
    logic [11:0] r_digi;

    // Address decode.
    logic w_sel_th;
    logic w_sel_tl;
    logic w_sel_tcon;
    logic w_sel_led;
    logic w_sel_switch;
    logic w_sel_digi;

    // Qualified write strobes (SWITCH is read-only, so it has none).
    logic w_wr_th;
    logic w_wr_tl;
    logic w_wr_tcon;
    logic w_wr_led;
    logic w_wr_digi;

    // Counter events.
    logic w_tl_max;
    logic w_overflow;
    logic w_status_set;
    logic [31:0] w_tl_inc;

    assign w_sel_th     = (addr == ADDR_TH);
    assign w_sel_tl     = (addr == ADDR_TL);
    assign w_sel_tcon   = (addr == ADDR_TCON);
    assign w_sel_led    = (addr == ADDR_LED);
    assign w_sel_switch = (addr == ADDR_SWITCH);
    assign w_sel_digi   = (addr == ADDR_DIGI);

    assign w_wr_th   = wr & w_sel_th;
    assign w_wr_tl   = wr & w_sel_tl;
    assign w_wr_tcon = wr & w_sel_tcon;
    assign w_wr_led  = wr & w_sel_led;
    assign w_wr_digi = wr & w_sel_digi;

    // An overflow is a counting cycle with TL at all-ones. It is defined
    // independently of any CPU write to TL, so the status bit still latches
    // when software happens to store to TL on that same edge.
    assign w_tl_max     = (r_tl == 32'hFFFF_FFFF);
    assign w_overflow   = r_tcon[TCON_EN] & w_tl_max;
    assign w_status_set = w_overflow & r_tcon[TCON_IE];
    assign w_tl_inc     = r_tl + 32'd1;

    // TH: reload value, changed only by software. A write in an overflow
    // cycle is not seen by that cycle's reload, which samples the old r_th.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_th <= 32'h0000_0000;
        end else if (w_wr_th) begin
            r_th <= wdata;
        end
    end

    // TL: software write wins; otherwise count up when enabled and reload
    // from TH on the edge after reaching all-ones.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tl <= 32'h0000_0000;
        end else if (w_wr_tl) begin
            r_tl <= wdata;
        end else if (r_tcon[TCON_EN]) begin
            if (w_tl_max) begin
                r_tl <= r_th;
            end else begin
                r_tl <= w_tl_inc;
            end
        end
    end

    // TCON: software write replaces all three bits (clearing a pending status
    // and dropping a same-edge overflow); otherwise the status bit is sticky.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tcon <= 3'b000;
        end else if (w_wr_tcon) begin
            r_tcon <= wdata[2:0];
        end else if (w_status_set) begin
            r_tcon[TCON_STS] <= 1'b1;
        end
    end

    // LED output register; only the low byte of the store is kept.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_led <= 8'h00;
        end else if (w_wr_led) begin
            r_led <= wdata[7:0];
        end
    end

    // 7-segment output register: [11:8] digit select, [7:0] segments.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_digi <= 12'h000;
        end else if (w_wr_digi) begin
            r_digi <= wdata[11:0];
        end
    end

    // Combinational load data: zero unless a mapped register is being read.
    always_comb begin
        rdata = 32'h0000_0000;
        if (rd) begin
            if (w_sel_th) begin
                rdata = r_th;
            end else if (w_sel_tl) begin
                rdata = r_tl;
            end else if (w_sel_tcon) begin
                rdata = {29'b0, r_tcon};
            end else if (w_sel_led) begin
                rdata = {24'b0, r_led};
            end else if (w_sel_switch) begin
                rdata = {24'b0, switch};
            end else if (w_sel_digi) begin
                rdata = {20'b0, r_digi};
            end
        end
    end

    assign led  = r_led;
    assign digi = r_digi;

    // The interrupt is masked while the MEM-stage instruction runs in kernel
    // mode, so a handler is not re-entered before it clears the status bit.
    assign irq = r_tcon[TCON_IE] & r_tcon[TCON_STS] & ~supervisor;

endmodule

// File: doc/timer_periph.md
# timer_periph

Memory-mapped timer/IO responder on the CPU's MEM-stage data bus. It answers `rd`/`wr` accesses from the pipeline's load/store path, exposes timer, LED, switch and 7-segment registers, and raises `irq` toward the control unit when the timer overflows. Read data is combinational so the pipeline can latch it into MEM/WB in the same cycle. Writes commit on the clock edge.

## Interface
- `TIMER_BASE`, default `32'h40000000`: base byte address of the register window.
- `clk` in 1: system clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-low reset.
- `rd` in 1: MEM-stage read strobe (`MemRd`).
- `wr` in 1: MEM-stage write strobe (`MemWr`).
- `addr` in 32: byte address (`ALUOut`).
- `wdata` in 32: store data (`DataBusB`).
- `rdata` out 32: load data, combinational.
- `supervisor` in 1: PC[31] of the MEM-stage instruction; 1 means kernel mode.
- `switch` in 8: board switches.
- `led` out 8: board LEDs.
- `digi` out 12: 7-segment drive, bits [11:8] digit select and [7:0] segments.
- `irq` out 1: timer interrupt request.

## Operation
- **Register map.** Exact full 32-bit address compare, offsets from `TIMER_BASE`:
  - 0x00 TH (rw 32): reload value.
  - 0x04 TL (rw 32): counter.
  - 0x08 TCON (rw 3): bit0 enable, bit1 interrupt enable, bit2 status.
  - 0x0C LED (rw 8).
  - 0x10 SWITCH (ro 8).
  - 0x14 DIGI (rw 12).
- **Read path.**
  - `rdata` = selected register, zero-extended to 32 bits, when `rd`=1 and the address is mapped.
  - `rdata` = 0 when `rd`=0 or the address is unmapped.
  - SWITCH returns the live `switch` input.
- **Write path.**
  - When `wr`=1 and the address is mapped, the register takes the low bits of `wdata`; upper bits are discarded.
  - Writes to SWITCH or to unmapped addresses are ignored.
  - `rd` and `wr` both high is legal: the read returns the pre-write value.
- **Counter behaviour.** When TCON.bit0=1 and TL is not being written:
  - TL != FFFFFFFF: TL <= TL+1.
  - TL == FFFFFFFF: TL <= TH. If TCON.bit1=1, also set TCON.bit2 <= 1.
  - TCON.bit0=0: TL holds.
- **Interrupt.** `irq` = TCON.bit1 & TCON.bit2 & ~`supervisor`. Combinational from registers plus the `supervisor` input.
- **Status bit.** TCON.bit2 is sticky. Only a CPU write or reset clears it.
- **Simultaneous events** (CPU write wins its targeted register):
  - Write to TL in an overflow cycle: TL takes `wdata`, not TH. The status bit still sets if bit1 was 1.
  - Write to TCON in an overflow cycle: TCON takes `wdata[2:0]` exactly. The overflow status set is dropped.
  - Write to TH in an overflow cycle: the reload uses the old TH. The new TH is visible from the next cycle.
- **Reset values** (reset=0 at a rising edge): TH=0, TL=0, TCON=0, LED=0, DIGI=0.
  - Therefore `led`=0, `digi`=0, `irq`=0.
  - `rdata` follows its combinational rule and is 0 when `rd`=0.
  - Reset overrides any concurrent write or count.

## Timing
- Read latency 0: `rdata` is valid in the same cycle as `rd`/`addr`.
- Write latency 1: the register shows the new value after the edge on which `wr`=1.
- Count: the first increment happens on the first edge after the edge that set TCON.bit0.
- Overflow: TL reaches FFFFFFFF at edge N. TL=TH and bit2=1 after edge N+1. `irq` rises in the cycle after edge N+1 if `supervisor`=0.
- No internal state machine beyond the counter. Period with TCON.bit1=1 is (FFFFFFFF−TH+1) cycles per interrupt.

## Test plan
- **Reset.** Hold reset=0 for 2 cycles with `wr`=1 at TH → all registers read 0 (`led`=0, `digi`=0, `irq`=0).
- **Overflow and reload.**
  - Stimulus: write TH=FFFFFFFC, TL=FFFFFFFE, TCON=3.
  - Required: TL reads FFFFFFFF, then FFFFFFFC, then FFFFFFFD.
  - Required: TCON reads 7 and `irq`=1 from the reload cycle onward.
- **Interrupt clear and masking.**
  - With the status bit set, `supervisor`=1 → `irq`=0. Return `supervisor`=0 → `irq`=1.
  - Write TCON=3 → `irq`=0 on the next cycle. Counting continues.
- **Write/overflow collision.**
  - Write TL=00000010 on the overflow edge → TL=00000011 next cycle, status set.
  - Repeat with a TCON=1 write instead → TCON reads 1.
- **IO registers.**
  - Write LED=0x1A5 → `led`=A5, reads 000000A5.
  - Write DIGI=0xFFFF → `digi`=FFF.
  - Switch=3C → SWITCH reads 0000003C. A write to SWITCH has no effect.
  - Read 0x40000018 → 0. Read any address with `rd`=0 → 0.
- **Reset mid-count.** TL counting with TCON=3, assert reset=0 for one edge → TL=0, TCON=0, no further counting after release.
